// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: single-cycle dmem path plus a handshaked peripheral path with timeout.
// Optional build macro LSU_MISALIGN_TRAP_EN adds misaligned-access suppression and the MisalignM output.
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic        IsPerM,
    input  logic [1:0]  MemSizeM,
    input  logic        LoadUnsignedM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    output logic        dmem_we,
    input  logic [31:0] dmem_rdata,
    output logic        per_req,
    output logic        per_we,
    output logic [31:0] per_addr,
    output logic [31:0] per_wdata,
    output logic [3:0]  per_wstrb,
    input  logic        per_ready,
    input  logic [31:0] per_rdata,
    output logic [31:0] ReadDataM,
    output logic        LsuStallM,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic        MisalignM,
`endif
    output logic        BusErrM
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} lsuState_t;

    lsuState_t         state;
    logic [TMO_W-1:0]  tmoCnt;
    logic [31:0]       capWord;
    logic              errFlag;
    logic              misalign;
    logic              perStart;
    logic [31:0]       laneData;
    logic [3:0]        laneStrb;
    logic [31:0]       srcWord;
    logic [31:0]       shifted;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = (MemReadM | MemWriteM) &
                      (((MemSizeM == 2'b01) & ALUResultM[0]) | (MemSizeM[1] & (|ALUResultM[1:0])));
    assign MisalignM = misalign;
`else
    assign misalign = 1'b0;
`endif

    assign perStart = IsPerM & (MemReadM | MemWriteM) & ~misalign;

    // Store lane replication; strobes wrap within the word for unaligned sizes.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        laneData = WriteDataM;
        laneStrb = 4'b1111;
        case (MemSizeM)
            2'b00: begin
                laneData = {4{WriteDataM[7:0]}};
                laneStrb = 4'b0001 << ALUResultM[1:0];
            end
            2'b01: begin
                laneData = {2{WriteDataM[15:0]}};
                laneStrb = ALUResultM[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
        if (!MemWriteM || misalign)
            laneStrb = 4'b0000;
    end

    assign dmem_addr  = {ALUResultM[31:2], 2'b00};
    assign dmem_wdata = laneData;
    assign dmem_wstrb = laneStrb;
    assign dmem_we    = MemWriteM & ~IsPerM & ~misalign;

    assign srcWord = IsPerM ? capWord : dmem_rdata;
    assign shifted = srcWord >> {ALUResultM[1:0], 3'b000};

    always_comb begin
        ReadDataM = shifted;
        case (MemSizeM)
            2'b00:   ReadDataM = {{24{~LoadUnsignedM & shifted[7]}}, shifted[7:0]};
            2'b01:   ReadDataM = {{16{~LoadUnsignedM & shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
        if (!MemReadM || misalign)
            ReadDataM = 32'h0;
    end

    // Stall is gated by rst so an asynchronous reset mid-access releases it immediately.
    assign LsuStallM = rst & (((state == IDLE) & perStart) | (state == REQ));
    assign BusErrM   = (state == DONE) & errFlag;

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            per_req   <= 1'b0;
            per_we    <= 1'b0;
            per_addr  <= 32'h0;
            per_wdata <= 32'h0;
            per_wstrb <= 4'b0000;
            capWord   <= 32'h0;
            tmoCnt    <= '0;
            errFlag   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (perStart) begin
                        state     <= REQ;
                        per_req   <= 1'b1;
                        per_we    <= MemWriteM;
                        per_addr  <= ALUResultM;
                        per_wdata <= laneData;
                        per_wstrb <= laneStrb;
                        tmoCnt    <= '0;
                        errFlag   <= 1'b0;
                    end
                end
                REQ: begin
                    tmoCnt <= tmoCnt + 1'b1;
                    if (per_ready) begin
                        capWord <= per_rdata;
                        per_req <= 1'b0;
                        state   <= DONE;
                    end else if (tmoCnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        capWord <= 32'h0;
                        errFlag <= 1'b1;
                        per_req <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    errFlag <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu (timeout shortened to 4 REQ cycles).
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MemReadM = 1'b0, MemWriteM = 1'b0, IsPerM = 1'b0, LoadUnsignedM = 1'b0;
    logic [1:0]  MemSizeM = 2'b00;
    logic [31:0] ALUResultM = 32'h0, WriteDataM = 32'h0;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 32'h0;
    logic [3:0]  dmem_wstrb;
    logic        dmem_we;
    logic        per_req, per_we, per_ready = 1'b0;
    logic [31:0] per_addr, per_wdata, per_rdata = 32'h0;
    logic [3:0]  per_wstrb;
    logic [31:0] ReadDataM;
    logic        LsuStallM, BusErrM;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        MisalignM;
`endif

    int errCnt = 0;
    int chkCnt = 0;
    int stallCycles;

    mem_stage_lsu #(.TIMEOUT_CYCLES(4), .TMO_W(8)) dut (
        .clk(clk), .rst(rst),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .IsPerM(IsPerM),
        .MemSizeM(MemSizeM), .LoadUnsignedM(LoadUnsignedM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_we(dmem_we), .dmem_rdata(dmem_rdata),
        .per_req(per_req), .per_we(per_we), .per_addr(per_addr),
        .per_wdata(per_wdata), .per_wstrb(per_wstrb),
        .per_ready(per_ready), .per_rdata(per_rdata),
        .ReadDataM(ReadDataM), .LsuStallM(LsuStallM),
`ifdef LSU_MISALIGN_TRAP_EN
        .MisalignM(MisalignM),
`endif
        .BusErrM(BusErrM)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic setAcc(input logic rd, input logic wr, input logic per, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd);
        MemReadM      = rd;
        MemWriteM     = wr;
        IsPerM        = per;
        MemSizeM      = sz;
        LoadUnsignedM = uns;
        ALUResultM    = addr;
        WriteDataM    = wd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        #3;
        check("rst_per_req", per_req, 0);
        check("rst_stall", LsuStallM, 0);
        check("rst_buserr", BusErrM, 0);
        check("rst_per_addr", per_addr, 0);
        check("rst_per_wstrb", per_wstrb, 0);
        @(negedge clk); rst = 1'b1;

        // dmem byte store at 0x103
        @(negedge clk); setAcc(0, 1, 0, 2'b00, 0, 32'h103, 32'h0000_00A5); #1;
        check("sb_wstrb", dmem_wstrb, 4'b1000);
        check("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
        check("sb_we", dmem_we, 1);
        check("sb_addr", dmem_addr, 32'h100);
        check("sb_stall", LsuStallM, 0);

        // dmem half/word stores
        setAcc(0, 1, 0, 2'b01, 0, 32'h2, 32'h1234_BEEF); #1;
        check("sh_wstrb", dmem_wstrb, 4'b1100);
        check("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
        setAcc(0, 1, 0, 2'b10, 0, 32'h8, 32'h1357_9BDF); #1;
        check("sw_wstrb", dmem_wstrb, 4'b1111);
        check("sw_wdata", dmem_wdata, 32'h13579BDF);

        // dmem loads from 0x8001_1234
        dmem_rdata = 32'h8001_1234;
        setAcc(1, 0, 0, 2'b01, 0, 32'h202, 0); #1;
        check("lh_signed", ReadDataM, 32'hFFFF8001);
        check("lh_wstrb", dmem_wstrb, 4'b0000);
        check("lh_we", dmem_we, 0);
        setAcc(1, 0, 0, 2'b01, 1, 32'h202, 0); #1;
        check("lhu", ReadDataM, 32'h00008001);
        setAcc(1, 0, 0, 2'b00, 0, 32'h201, 0); #1;
        check("lb_pos", ReadDataM, 32'h00000012);
        setAcc(1, 0, 0, 2'b00, 0, 32'h203, 0); #1;
        check("lb_neg", ReadDataM, 32'hFFFFFF80);
        setAcc(1, 0, 0, 2'b10, 0, 32'h200, 0); #1;
        check("lw", ReadDataM, 32'h80011234);
        setAcc(0, 0, 0, 2'b10, 0, 32'h200, 0); #1;
        check("no_read_zero", ReadDataM, 32'h0);

`ifdef LSU_MISALIGN_TRAP_EN
        setAcc(0, 1, 0, 2'b10, 0, 32'h6, 32'hFFFF_FFFF); #1;
        check("mis_flag", MisalignM, 1);
        check("mis_we", dmem_we, 0);
        check("mis_wstrb", dmem_wstrb, 4'b0000);
        setAcc(0, 1, 1, 2'b10, 0, 32'h4000_0006, 32'hFFFF_FFFF); #1;
        check("mis_per_stall", LsuStallM, 0);
        @(negedge clk); #1;
        check("mis_per_req", per_req, 0);
        setAcc(1, 0, 0, 2'b01, 0, 32'h201, 0); #1;
        check("mis_load_zero", ReadDataM, 32'h0);
`else
        setAcc(0, 1, 0, 2'b01, 0, 32'h3, 32'h0000_BEEF); #1;
        check("unal_sh_wstrb", dmem_wstrb, 4'b1100);
        check("unal_sh_we", dmem_we, 1);
        setAcc(1, 0, 0, 2'b10, 0, 32'h1, 0); #1;
        check("unal_lw", ReadDataM, 32'h00800112);
`endif

        // Peripheral word read, per_ready on the 3rd REQ cycle
        @(negedge clk); setAcc(1, 0, 1, 2'b10, 0, 32'h4000_0008, 0); per_ready = 1'b0; #1;
        stallCycles = 0;
        check("pr_idle_stall", LsuStallM, 1);
        check("pr_idle_req", per_req, 0);
        check("pr_dmem_we", dmem_we, 0);
        if (LsuStallM) stallCycles++;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            per_ready = (k == 3);
            per_rdata = (k == 3) ? 32'hCAFEF00D : 32'h1111_1111;
            #1;
            check("pr_req", per_req, 1);
            if (k == 1) begin
                check("pr_addr", per_addr, 32'h4000_0008);
                check("pr_we", per_we, 0);
            end
            if (LsuStallM) stallCycles++;
        end
        @(negedge clk); per_ready = 1'b0; per_rdata = 32'hDEAD_BEEF; #1;
        check("pr_done_req", per_req, 0);
        check("pr_done_stall", LsuStallM, 0);
        check("pr_done_data", ReadDataM, 32'hCAFEF00D);
        check("pr_done_err", BusErrM, 0);
        check("pr_stall_cycles", stallCycles, 4);
        @(negedge clk); setAcc(0, 0, 0, 2'b00, 0, 0, 0); #1;
        check("pr_after_req", per_req, 0);

        // Peripheral byte store, never ready; per_ready in IDLE is ignored
        @(negedge clk); setAcc(0, 1, 1, 2'b00, 0, 32'h4000_0011, 32'h0000_005A); per_ready = 1'b1; #1;
        check("ps_idle_stall", LsuStallM, 1);
        check("ps_dmem_we", dmem_we, 0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); per_ready = 1'b0; #1;
            check("ps_req", per_req, 1);
            check("ps_stall", LsuStallM, 1);
            if (k == 1) begin
                check("ps_we", per_we, 1);
                check("ps_wstrb", per_wstrb, 4'b0010);
                check("ps_wdata", per_wdata, 32'h5A5A5A5A);
                check("ps_addr", per_addr, 32'h4000_0011);
            end
        end
        @(negedge clk); #1;
        check("ps_done_req", per_req, 0);
        check("ps_done_err", BusErrM, 1);
        check("ps_done_data", ReadDataM, 32'h0);
        check("ps_done_stall", LsuStallM, 0);
        @(negedge clk); setAcc(0, 0, 0, 2'b00, 0, 0, 0); #1;
        check("ps_err_pulse", BusErrM, 0);

        // Peripheral read timeout captures zero even with busy rdata
        @(negedge clk); setAcc(1, 0, 1, 2'b10, 0, 32'h4000_0000, 0); per_rdata = 32'hFFFF_FFFF;
        repeat (5) @(negedge clk);
        #1;
        check("rt_done_err", BusErrM, 1);
        check("rt_done_data", ReadDataM, 32'h0);
        @(negedge clk); setAcc(0, 0, 0, 2'b00, 0, 0, 0); #1;

        // Reset during REQ
        @(negedge clk); setAcc(1, 0, 1, 2'b10, 0, 32'h4000_0004, 0); #1;
        @(negedge clk); #1;
        check("rr_req_before", per_req, 1);
        rst = 1'b0; #1;
        check("rr_req_drop", per_req, 0);
        check("rr_stall_drop", LsuStallM, 0);
        @(negedge clk); rst = 1'b1; setAcc(0, 0, 0, 2'b00, 0, 0, 0); #1;
        check("rr_idle_req", per_req, 0);
        @(negedge clk); #1;
        check("rr_no_err", BusErrM, 0);
        check("rr_still_idle", per_req, 0);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-stage load/store unit at the consumer end of the EXE/MEM pipeline register. It takes the M-stage access fields and performs the access on either the single-cycle data memory or the handshaked peripheral bus. It aligns store data and strobes and extracts and extends load data. While a peripheral access is outstanding it drives the M-stage stall back to the hazard unit.

## Interface
- TIMEOUT_CYCLES, 255: maximum REQ cycles without per_ready before the access is aborted.
- TMO_W, 8: width of the timeout counter; must hold TIMEOUT_CYCLES.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- MemReadM  in  1  load in M stage.
- MemWriteM  in  1  store in M stage.
- IsPerM  in  1  access targets the peripheral bus, not dmem.
- MemSizeM  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- LoadUnsignedM  in  1  zero-extend loads when 1, sign-extend when 0.
- ALUResultM  in  32  byte address.
- WriteDataM  in  32  store data, LSB-aligned.
- dmem_addr  out  32  word address {ALUResultM[31:2],2'b00}.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_wstrb  out  4  byte enables.
- dmem_we  out  1  dmem write enable (written at clk edge).
- dmem_rdata  in  32  combinational dmem read word.
- per_req  out  1  peripheral request, registered.
- per_we  out  1  peripheral write.
- per_addr  out  32  peripheral byte address.
- per_wdata  out  32  lane-replicated store data.
- per_wstrb  out  4  byte enables.
- per_ready  in  1  peripheral completion; per_rdata valid in the same cycle.
- per_rdata  in  32  peripheral read word.
- ReadDataM  out  32  extended load result.
- LsuStallM  out  1  stall request to the hazard unit, ORed into StallM.
- BusErrM  out  1  one-cycle pulse in DONE when the peripheral access timed out.

## Operation
- Store lanes:
  - Byte: wdata = {4{WriteDataM[7:0]}}, wstrb = 0001 << addr[1:0].
  - Half: wdata = {2{WriteDataM[15:0]}}, wstrb = addr[1] ? 1100 : 0011.
  - Word: wdata = WriteDataM, wstrb = 1111.
  - wstrb = 0000 when MemWriteM = 0.
- Load extraction:
  - The selected word is shifted right by addr[1:0]*8.
  - Byte loads take bits [7:0] and half loads take bits [15:0].
  - The result is sign- or zero-extended per LoadUnsignedM.
  - ReadDataM = 0 when MemReadM = 0.
- dmem path (IsPerM = 0):
  - Zero-latency path: dmem_we = MemWriteM and ReadDataM comes from dmem_rdata.
  - LsuStallM stays 0.
- Peripheral path, FSM IDLE, REQ, DONE:
  - IDLE: if IsPerM & (MemReadM|MemWriteM), go to REQ. LsuStallM = 1 combinationally in this cycle.
  - REQ: per_req = 1 and LsuStallM = 1. per_we, per_addr, per_wdata and per_wstrb are registered at IDLE→REQ and held stable.
  - REQ with per_ready = 1: capture per_rdata, go to DONE.
  - REQ with counter = TIMEOUT_CYCLES-1 and no per_ready: capture 0, set the error flag, go to DONE.
  - DONE: per_req = 0 and LsuStallM = 0. ReadDataM comes from the captured word. BusErrM = error flag. Return to IDLE.
- The pipeline advances the M stage at the end of DONE, so a peripheral access in IDLE is always a new instruction.
- dmem_we = 0 whenever IsPerM = 1.
- Reset values: state IDLE, per_req 0, per_we 0, per_addr 0, per_wdata 0, per_wstrb 0, captured word 0, timeout counter 0, error flag 0, BusErrM 0, LsuStallM 0.

## Timing
- dmem access: 0 extra cycles.
- Peripheral access: minimum 3 cycles in M (IDLE, one REQ cycle with per_ready, DONE). Each REQ cycle without per_ready adds 1 cycle.
- per_req deasserts on the clock edge after per_ready is sampled high.
- per_ready outside REQ is ignored.
- The timeout counter clears on entry to REQ and increments every REQ cycle.
- Timeout abort: TIMEOUT_CYCLES REQ cycles, then DONE.
- Reset mid-REQ drops per_req asynchronously. The access is lost and no BusErrM is raised.

## Configuration
- LSU_MISALIGN_TRAP_EN, when defined:
  - A half access with addr[0] = 1, or a word access with addr[1:0] ≠ 00, is misaligned.
  - A misaligned access gives dmem_we = 0 and wstrb = 0000, never starts a peripheral request, and forces ReadDataM = 0.
  - It asserts output MisalignM (1 bit, combinational) for that cycle.
- When undefined:
  - The MisalignM port is absent.
  - Misaligned accesses use the low address bits as given. Lanes wrap within the word, and only in-word bytes are written.

## Test plan
- Store byte 0xA5 to dmem addr 0x103 -> dmem_wstrb = 1000, dmem_wdata = 0xA5A5A5A5, dmem_we = 1, LsuStallM = 0.
- Signed half load at 0x202 with dmem_rdata = 0x8001_1234 -> ReadDataM = 0xFFFF8001; with LoadUnsignedM = 1 -> 0x00008001.
- Peripheral word read at 0x4000_0008, per_ready raised on the 3rd REQ cycle with per_rdata = 0xCAFEF00D -> LsuStallM high for 4 cycles, then ReadDataM = 0xCAFEF00D in DONE.
- Peripheral store, per_ready never asserted, TIMEOUT_CYCLES = 4 -> per_req high for 4 cycles, then DONE with BusErrM = 1 and ReadDataM = 0.
- rst pulled low during REQ -> per_req = 0 and LsuStallM = 0 immediately; after release, state IDLE.
- LSU_MISALIGN_TRAP_EN defined, word store at 0x6 -> MisalignM = 1, dmem_we = 0, per_req stays 0.
